gray_code_tracker: RTL and testbench
====================================

# gray_code_tracker

Receive-side companion to the Gray-code counter. Samples a WIDTH-bit reflected Gray code from an upstream generator (a Gray counter or a rotary/position encoder). Decodes it to binary and classifies every transition as step-up, step-down, hold or illegal. Keeps a signed running position and reports errors, so downstream logic can consume a clean binary position and direction.

## Interface
- WIDTH, 3, width of the Gray code input (≥2)
- PWIDTH, 8, width of the signed Position accumulator
- clock  in  1  rising-edge clock for all state
- reset_b  in  1  asynchronous, active-low reset
- Sample  in  1  GrayIn is valid this cycle
- GrayIn  in  WIDTH  reflected Gray code from upstream
- Clear  in  1  synchronous return to UNLOCKED; zeroes Position, Bin and ErrSticky
- Bin  out  WIDTH  binary value of the last accepted code
- Position  out  PWIDTH  signed step count since lock/clear
- Up  out  1  one-cycle pulse: accepted +1 step
- Down  out  1  one-cycle pulse: accepted −1 step
- Err  out  1  one-cycle pulse: illegal transition
- ErrSticky  out  1  set by any Err; cleared only by Clear or reset
- Locked  out  1  high while in LOCKED

## Operation
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i], combinational on GrayIn.
- Let nb be the decoded GrayIn and pb be the registered Bin.
- Diff d = (nb − pb) mod 2^WIDTH:
  - d = 0 is a hold.
  - d = 1 is up.
  - d = 2^WIDTH−1 is down.
  - Any other value is illegal. This includes single-bit Gray changes that are not adjacent codes, e.g. 001→101.
- Wrap is legal: 100→000 (bin 7→0) is up; 000→100 is down.
- FSM states are UNLOCKED, LOCKED and FAULT. Reset state is UNLOCKED.
- UNLOCKED:
  - On Sample, latch Bin = nb and go to LOCKED.
  - No Up, Down or Err pulse; Position unchanged.
- LOCKED, on Sample:
  - Hold: no change.
  - Up: Bin = nb, Position += 1, pulse Up.
  - Down: Bin = nb, Position −= 1, pulse Down.
  - Illegal: Bin = nb (rebaseline), Position held, pulse Err, set ErrSticky, go to FAULT.
- FAULT, on Sample:
  - Up or down: update as in LOCKED and return to LOCKED.
  - Hold: stay in FAULT.
  - Illegal: rebaseline, pulse Err again, stay in FAULT.
- No Sample: all state is held and no pulses are produced, in every state.
- Position wraps two's-complement modulo 2^PWIDTH. No saturation and no overflow flag.
- Clear has priority over a Sample in the same cycle:
  - State goes to UNLOCKED; Bin = 0; Position = 0; ErrSticky = 0; no pulses.
  - The coincident Sample is discarded.
- At most one of Up, Down or Err is high in any cycle.

## Timing
- All outputs are registered.
- A Sample at edge N is reflected in Bin, Position, the pulses and Locked after edge N (valid during cycle N+1).
- Up, Down and Err are high for exactly one cycle per accepted Sample. Back-to-back Samples give back-to-back pulses.
- Samples may arrive every cycle (full throughput, no stall, no backpressure).
- Reset values: Bin = 0, Position = 0, Up = Down = Err = 0, ErrSticky = 0, Locked = 0, state UNLOCKED.
- Reset asserted mid-operation clears everything immediately (asynchronously). The first Sample after reset release only latches a baseline.
- GrayIn is in the clock domain; any synchronization is the integrator's responsibility.

## Test plan
- Reset, then Sample each cycle with GrayIn 000,001,011,010,110,111,101,100,000 (WIDTH=3):
  - Locked rises after the first Sample.
  - Eight Up pulses.
  - Bin runs 0..7 then 0.
  - Position = 8.
  - Err never set.
- From lock at 000, Sample 100,101,111,110:
  - Four Down pulses.
  - Bin = 7,6,5,4.
  - Position = −4 (8'hFC).
- Locked at 000, Sample 011:
  - Err pulses once; ErrSticky = 1; Locked = 0.
  - Bin = 2; Position unchanged.
  - Then Sample 010: Up pulse, Bin = 3, Locked = 1, ErrSticky stays 1.
- Locked at 001, Sample 101 (single-bit but non-adjacent) → Err pulse, FAULT, Position unchanged.
- Sample with the same code repeatedly, and cycles with Sample = 0 → no pulses, no Position change.
- Position = 127, one up step → Position = −128.
- Clear and Sample asserted in the same cycle:
  - Position = 0, Bin = 0, ErrSticky = 0, Locked = 0, no pulse.
  - The next Sample only relocks.
- Assert reset_b low between clock edges mid-sequence → all outputs are 0 immediately. After release, the first Sample produces no Up, Down or Err.

Source files
------------

// File: rtl/gray_code_tracker.sv
// Gray-code position tracker: decodes a reflected Gray input and accumulates a signed step position.
// Latency: one cycle from a Sample edge to Bin/Position/Up/Down/Err/Locked.
// Backpressure: none; a Sample can be taken every cycle, and Clear overrides a coincident Sample.
//
// Ports:
//   clock, reset_b     : rising-edge clock, asynchronous active-low reset
//   Sample, GrayIn     : GrayIn is valid when Sample is high
//   Clear              : synchronous return to UNLOCKED, zeroes Bin/Position/ErrSticky
//   Bin, Position      : last accepted binary code, signed step count since lock/clear
//   Up, Down, Err      : one-cycle pulses per accepted step or illegal transition
//   ErrSticky, Locked  : latched error flag, high while tracking in LOCKED
module gray_code_tracker #(
    parameter int WIDTH  = 3,
    parameter int PWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              Sample,
    input  logic [WIDTH-1:0]  GrayIn,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Bin,
    output logic [PWIDTH-1:0] Position,
    output logic              Up,
    output logic              Down,
    output logic              Err,
    output logic              ErrSticky,
    output logic              Locked
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [PWIDTH-1:0]  pos_q, pos_d;
    logic               up_q, up_d;
    logic               down_q, down_d;
    logic               err_q, err_d;
    logic               sticky_q, sticky_d;

    logic [WIDTH-1:0]   nb;
    logic [WIDTH-1:0]   diff;
    logic               is_hold;
    logic               is_up;
    logic               is_down;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        nb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nb[i] = ^(GrayIn >> i);
        end
    end

    // Modular difference makes the 7->0 / 0->7 wraps fall out as ordinary up/down steps.
    assign diff    = nb - bin_q;
    assign is_hold = (diff == '0);
    assign is_up   = (diff == WIDTH'(1));
    assign is_down = (diff == '1);

    // State register
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_UNLOCKED;
            bin_q    <= '0;
            pos_q    <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            pos_q    <= pos_d;
            up_q     <= up_d;
            down_q   <= down_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        pos_d    = pos_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;

        if (Clear) begin
            state_d  = ST_UNLOCKED;
            bin_d    = '0;
            pos_d    = '0;
            sticky_d = 1'b0;
        end else if (Sample) begin
            case (state_q)
                ST_LOCKED, ST_FAULT: begin
                    if (is_up) begin
                        bin_d   = nb;
                        pos_d   = pos_q + PWIDTH'(1);
                        up_d    = 1'b1;
                        state_d = ST_LOCKED;
                    end else if (is_down) begin
                        bin_d   = nb;
                        pos_d   = pos_q - PWIDTH'(1);
                        down_d  = 1'b1;
                        state_d = ST_LOCKED;
                    end else if (!is_hold) begin
                        // Rebaseline on the new code so one glitch costs one error, not a stream.
                        bin_d    = nb;
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        state_d  = ST_FAULT;
                    end
                end
                default: begin
                    // First sample after reset/clear only establishes the baseline.
                    bin_d   = nb;
                    state_d = ST_LOCKED;
                end
            endcase
        end
    end

    // Outputs, all taken straight from registers
    always_comb begin
        Bin       = bin_q;
        Position  = pos_q;
        Up        = up_q;
        Down      = down_q;
        Err       = err_q;
        ErrSticky = sticky_q;
        Locked    = (state_q == ST_LOCKED);
    end

endmodule

// File: tb/tb_gray_code_tracker.sv
module tb_gray_code_tracker;

    logic       clock;
    logic       reset_b;
    logic       Sample;
    logic [2:0] GrayIn;
    logic       Clear;
    logic [2:0] Bin;
    logic [7:0] Position;
    logic       Up, Down, Err, ErrSticky, Locked;

    gray_code_tracker #(.WIDTH(3), .PWIDTH(8)) dut (
        .clock     (clock),
        .reset_b   (reset_b),
        .Sample    (Sample),
        .GrayIn    (GrayIn),
        .Clear     (Clear),
        .Bin       (Bin),
        .Position  (Position),
        .Up        (Up),
        .Down      (Down),
        .Err       (Err),
        .ErrSticky (ErrSticky),
        .Locked    (Locked)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [2:0] bin;
        logic [7:0] pos;
        logic       up;
        logic       down;
        logic       err;
        logic       sticky;
        logic       locked;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 = unlocked, 1 = locked, 2 = fault
    int         m_st;
    logic [2:0] m_bin;
    logic [7:0] m_pos;
    logic       m_sticky;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        case (g)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            3'b011:  return 3'd2;
            3'b010:  return 3'd3;
            3'b110:  return 3'd4;
            3'b111:  return 3'd5;
            3'b101:  return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st     = 0;
        m_bin    = 3'd0;
        m_pos    = 8'd0;
        m_sticky = 1'b0;
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic step(input logic s, input logic [2:0] g, input logic c);
        exp_t       e;
        logic [2:0] nb;
        logic [2:0] d;
        Sample = s;
        GrayIn = g;
        Clear  = c;
        e = '0;
        if (c) begin
            model_reset();
        end else if (s) begin
            nb = gray2bin(g);
            if (m_st == 0) begin
                m_bin = nb;
                m_st  = 1;
            end else begin
                d = nb - m_bin;
                if (d == 3'd1) begin
                    m_bin = nb; m_pos = m_pos + 8'd1; e.up = 1'b1; m_st = 1;
                end else if (d == 3'd7) begin
                    m_bin = nb; m_pos = m_pos - 8'd1; e.down = 1'b1; m_st = 1;
                end else if (d != 3'd0) begin
                    m_bin = nb; e.err = 1'b1; m_sticky = 1'b1; m_st = 2;
                end
            end
        end
        e.bin    = m_bin;
        e.pos    = m_pos;
        e.sticky = m_sticky;
        e.locked = (m_st == 1);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        Sample = 1'b0;
        Clear  = 1'b0;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("bin",    {29'd0, Bin},       {29'd0, e.bin});
            chk("pos",    {24'd0, Position},  {24'd0, e.pos});
            chk("up",     {31'd0, Up},        {31'd0, e.up});
            chk("down",   {31'd0, Down},      {31'd0, e.down});
            chk("err",    {31'd0, Err},       {31'd0, e.err});
            chk("sticky", {31'd0, ErrSticky}, {31'd0, e.sticky});
            chk("locked", {31'd0, Locked},    {31'd0, e.locked});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin"},    {29'd0, Bin},       32'd0);
        chk({tag, "_pos"},    {24'd0, Position},  32'd0);
        chk({tag, "_up"},     {31'd0, Up},        32'd0);
        chk({tag, "_down"},   {31'd0, Down},      32'd0);
        chk({tag, "_err"},    {31'd0, Err},       32'd0);
        chk({tag, "_sticky"}, {31'd0, ErrSticky}, 32'd0);
        chk({tag, "_locked"}, {31'd0, Locked},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] b;
        logic [2:0] fwd [9];
        fwd[0] = 3'b000; fwd[1] = 3'b001; fwd[2] = 3'b011; fwd[3] = 3'b010;
        fwd[4] = 3'b110; fwd[5] = 3'b111; fwd[6] = 3'b101; fwd[7] = 3'b100;
        fwd[8] = 3'b000;

        reset_b = 1'b0;
        Sample  = 1'b0;
        GrayIn  = 3'b000;
        Clear   = 1'b0;
        model_reset();
        #3;
        chk_all_zero("reset");
        @(posedge clock);
        #1;
        reset_b = 1'b1;

        // Full forward lap including the 7->0 wrap
        for (int i = 0; i < 9; i++) step(1'b1, fwd[i], 1'b0);
        chk("lap_pos", {24'd0, Position}, 32'd8);
        chk("lap_bin", {29'd0, Bin}, 32'd0);
        chk("lap_sticky", {31'd0, ErrSticky}, 32'd0);

        // Down steps through the 0->7 wrap
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b100, 1'b0);
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b110, 1'b0);
        chk("down_pos", {24'd0, Position}, 32'h0000_00FC);
        chk("down_bin", {29'd0, Bin}, 32'd4);

        // Illegal jump 0->2, then recovery by an up step
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b011, 1'b0);
        chk("illegal_bin", {29'd0, Bin}, 32'd2);
        chk("illegal_locked", {31'd0, Locked}, 32'd0);
        step(1'b1, 3'b011, 1'b0);     // hold while in fault
        step(1'b1, 3'b010, 1'b0);
        chk("recover_bin", {29'd0, Bin}, 32'd3);
        chk("recover_sticky", {31'd0, ErrSticky}, 32'd1);

        // Single-bit Gray change that is not adjacent: 001 -> 101
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b001, 1'b0);
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b000, 1'b0);     // illegal again while in fault
        chk("nonadj_pos", {24'd0, Position}, 32'd0);

        // Holds and idle cycles with a changing bus
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b110, 1'b0);
        step(1'b1, 3'b110, 1'b0);
        step(1'b1, 3'b110, 1'b0);
        step(1'b0, 3'b011, 1'b0);
        step(1'b0, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        step(1'b0, 3'b101, 1'b0);

        // Position wrap 127 -> -128
        step(1'b0, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b0);
        b = 3'd0;
        for (int i = 0; i < 127; i++) begin
            b = b + 3'd1;
            step(1'b1, b ^ (b >> 1), 1'b0);
        end
        chk("pos_127", {24'd0, Position}, 32'd127);
        b = b + 3'd1;
        step(1'b1, b ^ (b >> 1), 1'b0);
        chk("pos_wrap", {24'd0, Position}, 32'h0000_0080);

        // Clear with a coincident sample, after building up error state
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b011, 1'b1);
        chk_all_zero("clear");
        step(1'b1, 3'b010, 1'b0);     // relock only
        step(1'b1, 3'b110, 1'b0);

        // Asynchronous reset between edges
        step(1'b1, 3'b111, 1'b0);
        chk("pre_reset_locked", {31'd0, Locked}, 32'd1);
        #2;
        reset_b = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        #3;
        reset_b = 1'b1;
        step(1'b1, 3'b101, 1'b0);     // baseline only
        step(1'b1, 3'b100, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
